// File: rtl/systolic_drain.sv
// systolic_drain: drains one finished TILE x TILE accumulator tile from the
// bottom row of a systolic grid into a small row FIFO. The consumer reads the
// FIFO through a valid/ready handshake. Rows leave the grid bottom-first, so
// the first row pushed is grid row TILE-1 and the last is row 0.
// Optional feature macro: SYSTOLIC_DRAIN_ROW_TAG_EN adds port outRow. Each
// FIFO entry then also stores its grid row index, and outRow shows the index
// of the head entry.
module systolic_drain #(
    parameter int TILE       = 32,
    parameter int EXP_OUT    = 5,
    parameter int FRAC_OUT   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [EXP_OUT+FRAC_OUT:0]  cIn [0:TILE-1],
    output logic                       enableShiftOut,
    output logic [EXP_OUT+FRAC_OUT:0]  outData [0:TILE-1],
    output logic                       outValid,
    input  logic                       outReady,
    output logic                       busy,
    output logic                       done
`ifdef SYSTOLIC_DRAIN_ROW_TAG_EN
    ,output logic [$clog2(TILE)-1:0]   outRow
`endif
);

    localparam int W     = EXP_OUT + FRAC_OUT + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ROW_W = $clog2(TILE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [ROW_W-1:0]   row_cnt_r;
    logic [ROW_W-1:0]   row_cnt_s;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_s;
    logic               en_r;
    logic               en_s;
    logic               valid_r;
    logic               busy_r;
    logic               done_r;
    logic               push_s;
    logic               pop_s;
    logic [W-1:0]       mem_r [0:FIFO_DEPTH-1][0:TILE-1];
`ifdef SYSTOLIC_DRAIN_ROW_TAG_EN
    logic [ROW_W-1:0]   tag_r [0:FIFO_DEPTH-1];
`endif

    // Next-state, row counter and FIFO occupancy; every output is precomputed here and registered.
    always_comb begin
        state_s   = state_r;
        row_cnt_s = row_cnt_r;
        count_s   = count_r;
        push_s    = en_r;
        pop_s     = valid_r && outReady;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s   = DRAIN;
                    row_cnt_s = ROW_W'(TILE - 1);
                end else begin
                    state_s   = IDLE;
                end
            end
            DRAIN: begin
                if (push_s) begin
                    row_cnt_s = row_cnt_r - ROW_W'(1);
                    if (row_cnt_r == ROW_W'(0)) begin
                        state_s = FLUSH;
                    end else begin
                        state_s = DRAIN;
                    end
                end else begin
                    state_s = DRAIN;
                end
            end
            FLUSH: begin
                if (count_r == CNT_W'(0)) begin
                    state_s = DONE;
                end else begin
                    state_s = FLUSH;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_W'(1);
            2'b01:   count_s = count_r - CNT_W'(1);
            default: count_s = count_r;
        endcase
        // Shift enable for the coming cycle depends only on that cycle's registered state and count.
        en_s = (state_s == DRAIN) && (count_s < CNT_W'(FIFO_DEPTH));
    end

    // Control state, FIFO pointers and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            row_cnt_r <= {ROW_W{1'b0}};
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            en_r      <= 1'b0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            row_cnt_r <= row_cnt_s;
            count_r   <= count_s;
            en_r      <= en_s;
            valid_r   <= (count_s != CNT_W'(0));
            busy_r    <= (state_s != IDLE);
            done_r    <= (state_s == DONE);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Row storage; cleared on reset so the head row reads as zero afterwards.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                for (int j = 0; j < TILE; j++) begin
                    mem_r[i][j] <= {W{1'b0}};
                end
`ifdef SYSTOLIC_DRAIN_ROW_TAG_EN
                tag_r[i] <= {ROW_W{1'b0}};
`endif
            end
        end else if (push_s) begin
            for (int j = 0; j < TILE; j++) begin
                mem_r[wr_ptr_r][j] <= cIn[j];
            end
`ifdef SYSTOLIC_DRAIN_ROW_TAG_EN
            tag_r[wr_ptr_r] <= row_cnt_r;
`endif
        end
    end

    // Head entry of the FIFO; held stable until it is popped.
    always_comb begin
        for (int j = 0; j < TILE; j++) begin
            outData[j] = mem_r[rd_ptr_r][j];
        end
    end

    assign enableShiftOut = en_r;
    assign outValid       = valid_r;
    assign busy           = busy_r;
    assign done           = done_r;
`ifdef SYSTOLIC_DRAIN_ROW_TAG_EN
    assign outRow         = tag_r[rd_ptr_r];
`endif

endmodule

// File: tb/tb_systolic_drain.sv
// Testbench for systolic_drain (TILE=4, FIFO_DEPTH=2). A queue-based model of
// the tile drain is compared against the DUT on every cycle. Directed tiles
// additionally pin delivered rows, latency and reset behaviour to literal values.
module tb_systolic_drain;

    localparam int TILE  = 4;
    localparam int EXPW  = 5;
    localparam int FRACW = 8;
    localparam int DEPTH = 2;
    localparam int W     = EXPW + FRACW + 1;
    localparam int RW    = $clog2(TILE);
    localparam int PW    = TILE * W;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           outReady = 1'b0;
    logic [W-1:0]   cIn [0:TILE-1];
    logic [W-1:0]   outData [0:TILE-1];
    logic           enableShiftOut;
    logic           outValid;
    logic           busy;
    logic           done;
`ifdef SYSTOLIC_DRAIN_ROW_TAG_EN
    logic [RW-1:0]  outRow;
`endif

    systolic_drain #(.TILE(TILE), .EXP_OUT(EXPW), .FRAC_OUT(FRACW), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .start(start), .cIn(cIn),
        .enableShiftOut(enableShiftOut), .outData(outData), .outValid(outValid),
        .outReady(outReady), .busy(busy), .done(done)
`ifdef SYSTOLIC_DRAIN_ROW_TAG_EN
        , .outRow(outRow)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] packRow(input logic [W-1:0] r [0:TILE-1]);
        logic [63:0] res;
        res = 64'd0;
        for (int j = 0; j < TILE; j++) res = res | (64'(r[j]) << (j * W));
        return res;
    endfunction

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 pulling rows from grid, 2 waiting for FIFO to empty, 3 done pulse
    logic [63:0] mq [$];
    int          mt [$];
    int          mPhase = 0;
    int          mRem = 0;
    int          doneSeen = 0;

    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                mq.delete();
                mt.delete();
                mPhase = 0;
                mRem = 0;
            end else begin
                int  sz;
                bit  en;
                bit  pop;
                sz  = mq.size();
                en  = (mPhase == 1) && (sz < DEPTH);
                pop = (sz != 0) && (outReady === 1'b1);
                if (pop) begin
                    void'(mq.pop_front());
                    void'(mt.pop_front());
                end
                if (en) begin
                    mq.push_back(packRow(cIn));
                    mt.push_back(mRem - 1);
                end
                case (mPhase)
                    0: if (start === 1'b1) begin mPhase = 1; mRem = TILE; end
                    1: if (en) begin mRem--; if (mRem == 0) mPhase = 2; end
                    2: if (sz == 0) mPhase = 3;
                    default: mPhase = 0;
                endcase
            end
        end
    end

    // Compare process: DUT outputs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (reset === 1'b1) begin
                check("enableShiftOut", 64'(enableShiftOut), 64'((mPhase == 1) && (mq.size() < DEPTH)));
                check("outValid", 64'(outValid), 64'(mq.size() != 0));
                check("busy", 64'(busy), 64'(mPhase != 0));
                check("done", 64'(done), 64'(mPhase == 3));
                if (mq.size() != 0) begin
                    check("outData", packRow(outData), mq[0]);
`ifdef SYSTOLIC_DRAIN_ROW_TAG_EN
                    check("outRow", 64'(outRow), 64'(mt[0]));
`endif
                end
                if (done === 1'b1) doneSeen++;
            end
        end
    end

    // ---------------- directed tile driver ----------------
    int gotData [0:7];
    int gotTag [0:7];
    int nGot, enSeen, doneCyc, doneCnt;

    task automatic setRow(input int k);
        for (int j = 0; j < TILE; j++) cIn[j] = W'(17 * (k + 1) + j);
    endtask

    // mode 0: ready high; 1: ready low until cycle 'hold'; 2: ready toggles
    task automatic runTile(input int mode, input int hold);
        int  cyc;
        bit  fin;
        nGot = 0; enSeen = 0; doneCyc = -1; doneCnt = 0; fin = 1'b0;
        start = 1'b1;
        outReady = (mode != 1);
        @(posedge clock);
        for (cyc = 0; cyc < 40 && !fin; cyc++) begin
            @(negedge clock); #1;
            start = (cyc == 2) || (cyc == 5);
            case (mode)
                0: outReady = 1'b1;
                1: outReady = (cyc >= hold);
                default: outReady = (cyc % 2 == 0);
            endcase
            if (mode == 1 && cyc == hold - 1) begin
                check("bp_enCount", 64'(enSeen + (enableShiftOut ? 1 : 0)), 64'd2);
                check("bp_valid_held", 64'(outValid), 64'd1);
                check("bp_data_stable", 64'(outData[0]), 64'h11);
            end
            if (outValid && outReady && nGot < 8) begin
                gotData[nGot] = int'(outData[0]);
`ifdef SYSTOLIC_DRAIN_ROW_TAG_EN
                gotTag[nGot] = int'(outRow);
`endif
                nGot++;
            end
            if (enableShiftOut) begin
                setRow(enSeen);
                enSeen++;
            end
            if (done) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = cyc;
            end
            if (doneCyc >= 0 && cyc > doneCyc) fin = 1'b1;
        end
        start = 1'b0;
        if (!fin) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic checkDelivered(input string tag);
        check({tag, "_rows"}, 64'(nGot), 64'(TILE));
        check({tag, "_doneCount"}, 64'(doneCnt), 64'd1);
        for (int k = 0; k < TILE && k < nGot; k++) begin
            check({tag, "_order"}, 64'(gotData[k]), 64'(17 * (k + 1)));
`ifdef SYSTOLIC_DRAIN_ROW_TAG_EN
            check({tag, "_rowTag"}, 64'(gotTag[k]), 64'(TILE - 1 - k));
`endif
        end
    endtask

    task automatic checkZeroOutputs(input string tag);
        check({tag, "_enable"}, 64'(enableShiftOut), 64'd0);
        check({tag, "_valid"}, 64'(outValid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_data"}, packRow(outData), 64'd0);
`ifdef SYSTOLIC_DRAIN_ROW_TAG_EN
        check({tag, "_outRow"}, 64'(outRow), 64'd0);
`endif
    endtask

    initial begin
        int doneBefore;
        for (int j = 0; j < TILE; j++) cIn[j] = '0;
        #12;
        checkZeroOutputs("reset");
        @(negedge clock); #1;
        reset = 1'b1;
        @(negedge clock); #1;

        // ready held high: 4 shifts, rows in order, done 6 cycles after start
        runTile(0, 0);
        check("lat_enCount", 64'(enSeen), 64'd4);
        check("lat_doneCycle", 64'(doneCyc), 64'd6);
        checkDelivered("lat");

        // back-pressure: FIFO fills after 2 rows, then drains once ready rises
        runTile(1, 6);
        check("bp_enTotal", 64'(enSeen), 64'd4);
        checkDelivered("bp");

        // ready toggling during drain
        runTile(2, 0);
        checkDelivered("toggle");

        // asynchronous reset after two pushes
        start = 1'b1;
        outReady = 1'b0;
        @(posedge clock);
        enSeen = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock); #1;
            start = 1'b0;
            if (enableShiftOut) begin setRow(enSeen + 4); enSeen++; end
        end
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        checkZeroOutputs("asyncReset");
        @(negedge clock); #1;
        reset = 1'b1;
        @(negedge clock); #1;
        runTile(0, 0);
        checkDelivered("afterReset");

        // randomized traffic
        doneBefore = doneSeen;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clock); #1;
            start = ($urandom_range(0, 5) == 0);
            outReady = ($urandom_range(0, 2) != 0);
            for (int j = 0; j < TILE; j++) cIn[j] = W'($urandom);
        end
        start = 1'b0;
        outReady = 1'b1;
        repeat (20) @(negedge clock);
        check("random_tiles_completed", 64'(doneSeen - doneBefore >= 20), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
